// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter-width helper for serial_adder
package serial_adder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake and operand/result bus of serial_adder
interface serial_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around a single full_adder, start/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = clog2(WIDTH);
  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;
  full_adder u_fa (.a(sa[0]), .b(sb[0]), .cin(c), .sum(fa_sum), .cout(fa_cout));
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == ST_RUN) begin
        acc <= {fa_sum, acc[WIDTH-1:1]};
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        c   <= fa_cout;
        cnt <= cnt + CW'(1);
        if (last) begin
          bus.sum  <= {fa_sum, acc[WIDTH-1:1]};
          bus.cout <= fa_cout;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= ST_DONE;
        end
      end else if (bus.start) begin
        sa       <= bus.a;
        sb       <= bus.b;
        c        <= bus.cin;
        cnt      <= '0;
        bus.busy <= 1'b1;
        state    <= ST_RUN;
      end else begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=16)
module tb_serial_adder;
  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;
  logic [15:0] exp_prev;
  int          bad;
  serial_adder_if #(.WIDTH(16)) bus ();
  serial_adder #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                     input logic ci, input logic [15:0] es, input logic ec, input int poke);
    bus.a = ai;
    bus.b = bi;
    bus.cin = ci;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = 16'hdead;
    bus.b = 16'hbeef;
    bus.cin = ~ci;
    chk({tag, "_busy_e0"}, bus.busy, 1'b1);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      if (i == poke) begin
        bus.start = 1'b1;
        bus.a = 16'hAAAA;
      end
      tick();
      bus.start = 1'b0;
      if (!bus.busy || bus.done || bus.sum !== exp_prev) bad++;
    end
    chk({tag, "_run_stable"}, bad, 0);
    tick();
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_busy_off"}, bus.busy, 1'b0);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    exp_prev = es;
    tick();
    chk({tag, "_done_fall"}, bus.done, 1'b0);
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    exp_prev = 16'h0000;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
    bus.cin = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_cout", bus.cout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, -1);
    run("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, -1);
    run("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, -1);
    run("mixed", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, -1);
    run("poke", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 5);
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.a = 16'h00FF;
    bus.b = 16'h0001;
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (!bus.busy || bus.done) bad++;
    end
    chk("b2b_run1", bad, 0);
    tick();
    chk("b2b_done1", bus.done, 1'b1);
    chk("b2b_sum1", bus.sum, 16'h0002);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy2", bus.busy, 1'b1);
    chk("b2b_done_fall", bus.done, 1'b0);
    bad = 0;
    for (int i = 18; i < 33; i++) begin
      tick();
      if (!bus.busy || bus.done || bus.sum !== 16'h0002) bad++;
    end
    chk("b2b_run2", bad, 0);
    tick();
    chk("b2b_done2", bus.done, 1'b1);
    chk("b2b_sum2", bus.sum, 16'h0100);
    chk("b2b_cout2", bus.cout, 1'b0);
    tick();
    chk("b2b_end", bus.done | bus.busy, 1'b0);
    bus.a = 16'h1234;
    bus.b = 16'h4321;
    bus.cin = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_sum", bus.sum, 16'h0000);
    chk("mid_rst_cout", bus.cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done || bus.busy) bad++;
    end
    chk("no_done_after_rst", bad, 0);
    exp_prev = 16'h0000;
    run("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, -1);
    run("msb_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
